// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer (alu_serial_ctrl) and its alu1 slice.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND      = 3'd0,
        OP_NOT      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_TRANSFER = 3'd6,
        OP_TEST     = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Only ADD and SUB propagate a carry/borrow between bit slices.
    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: purely combinational, carry/borrow in and out for ADD/SUB.
// TRANSFER and TEST both pass operand a through; TEST exists so a value can be run for its flags.
module alu1
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    y,
    output logic    cout
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        y    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND:      y = a & b;
            OP_NOT:      y = ~a;
            OP_OR:       y = a | b;
            OP_XOR:      y = a ^ b;
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                // {borrow, y} = a - b - borrow_in
                y    = a ^ b ^ cin;
                cout = (~a & b) | (~a & cin) | (b & cin);
            end
            OP_TRANSFER: y = a;
            OP_TEST:     y = a;
            default: begin
                y    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around one alu1 slice: WIDTH-bit operation, LSB first, one bit per clock.
// Optional ALU_SERIAL_FLAGS_EN adds the zero/overflow flag logic; otherwise both flags are tied 0.
module alu_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             flag_zero,
    output logic             flag_ovf
);
    import alu_pkg::*;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             run;
    logic             last_bit;
    logic             slice_y;
    logic             slice_cout;

    assign accept   = (state_q == IDLE) && start_valid;
    assign run      = (state_q == RUN);
    assign last_bit = run && (cnt_q == LAST);

    alu1 u_alu1 (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .y    (slice_y),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)  state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_ready  = (state_q == IDLE);
        busy         = (state_q == RUN);
        result_valid = (state_q == DONE);
        result       = res_q;
        carry_out    = (state_q == DONE) && is_arith(op_q) && carry_q;
    end

    // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
    always_comb begin
        op_d    = op_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            op_d    = alu_op_e'(op);
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = carry_in;
            cnt_d   = '0;
        end else if (run) begin
            res_d   = {slice_y, res_q[WIDTH-1:1]};
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d = slice_cout;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // NOTE: the datapath is reset too, because result and carry_out must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_AND;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            op_q    <= op_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    // Carry into the MSB is the slice's carry-in while the last bit is processed.
    logic cmsb_q, cmsb_d;

    always_comb begin
        cmsb_d = cmsb_q;
        if (last_bit) cmsb_d = carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else begin
            cmsb_q <= cmsb_d;
        end
    end

    assign flag_zero = (state_q == DONE) && (res_q == '0);
    assign flag_ovf  = (state_q == DONE) && is_arith(op_q) && (cmsb_q ^ carry_q);
`else
    assign flag_zero = 1'b0;
    assign flag_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed cases plus random ops against an arithmetic model.
module tb_alu_serial_ctrl;

    localparam int W = 4;
`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         carry_in;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         busy;
    logic         flag_zero;
    logic         flag_ovf;

    int n_vec = 0;
    int n_err = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry_out    (carry_out),
        .busy         (busy),
        .flag_zero    (flag_zero),
        .flag_ovf     (flag_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sval(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Whole-word reference: integer arithmetic, no bit-serial modelling.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, output logic [W-1:0] r, output logic co,
                         output logic z, output logic v);
        int u, s;
        r  = '0;
        co = 1'b0;
        v  = 1'b0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = ~x;
            3'd2: r = x | y;
            3'd3: r = x ^ y;
            3'd4: begin
                u  = int'(x) + int'(y) + int'(c);
                r  = W'(u);
                co = (u >= (1 << W));
                s  = sval(x) + sval(y) + int'(c);
                v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
            end
            3'd5: begin
                u  = int'(x) - int'(y) - int'(c);
                r  = W'(u);
                co = (u < 0);
                s  = sval(x) - sval(y) - int'(c);
                v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
            end
            default: r = x;
        endcase
        z = (r == '0);
        if (!FLAGS) begin
            z = 1'b0;
            v = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input int hold, input bit glitch);
        logic [W-1:0] er;
        logic         eco, ez, ev;
        int           lat;
        model(o, x, y, c, er, eco, ez, ev);

        @(negedge clk);
        check("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        op = o; a = x; b = y; carry_in = c;
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("start_ready_run", start_ready, 0);

        lat = 0;
        while (!result_valid && lat < 4 * W) begin
            if (glitch) begin
                start_valid = 1'b1;
                op = 3'($urandom); a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start_valid = 1'b0;
        check("latency", lat, W);
        check("result", result, er);
        check("carry_out", carry_out, eco);
        check("flag_zero", flag_zero, ez);
        check("flag_ovf", flag_ovf, ev);
        check("busy_done", busy, 0);

        for (int i = 0; i < hold; i++) begin
            result_ready = 1'b0;
            if (glitch) begin
                start_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); #1;
            start_valid = 1'b0;
            check("hold_valid", result_valid, 1);
            check("hold_result", result, er);
            check("hold_carry", carry_out, eco);
            check("hold_start_ready", start_ready, 0);
        end

        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("valid_after_hs", result_valid, 0);
        check("flags_after_hs", {flag_zero, flag_ovf}, 2'b00);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        op = '0; a = '0; b = '0; carry_in = 1'b0;
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_outputs", {result_valid, result, carry_out, busy, flag_zero, flag_ovf}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd4, 4'h7, 4'h1, 1'b0, 0, 1'b0);
        run_op(3'd5, 4'h3, 4'h5, 1'b0, 0, 1'b0);
        run_op(3'd5, 4'h5, 4'h5, 1'b0, 0, 1'b0);
        run_op(3'd0, 4'hC, 4'hA, 1'b1, 0, 1'b0);
        run_op(3'd1, 4'h5, 4'h0, 1'b0, 0, 1'b0);
        run_op(3'd3, 4'hF, 4'h3, 1'b0, 0, 1'b0);
        run_op(3'd4, 4'hF, 4'hF, 1'b1, 0, 1'b0);
        run_op(3'd5, 4'h8, 4'h0, 1'b1, 0, 1'b0);
        run_op(3'd6, 4'h9, 4'h6, 1'b1, 0, 1'b0);
        run_op(3'd7, 4'h0, 4'hF, 1'b1, 0, 1'b0);
        run_op(3'd4, 4'h9, 4'h8, 1'b0, 3, 1'b0);
        run_op(3'd2, 4'h5, 4'h9, 1'b0, 2, 1'b1);

        // Reset while bit 2 is pending: op is dropped and no response appears.
        @(negedge clk);
        start_valid = 1'b1;
        op = 3'd4; a = 4'h9; b = 4'h3; carry_in = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {result_valid, result, carry_out, busy, flag_zero, flag_ovf}, '0);
        check("midrst_start_ready", start_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) seen = 1'b1;
        end
        check("midrst_no_response", seen, 0);
        run_op(3'd4, 4'h2, 4'h2, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
